// File: rtl/lc3_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_pipeline_ctrl
//
// Central sequencer for the LC3 pipeline (Fetch, Decode, Execute, Writeback
// plus a Memory access state machine). It produces the per-stage enables,
// the branch-taken PC select and the ALU bypass selects.
//
// Ports
//   clock            : system clock, rising edge
//   reset_n          : asynchronous active-low reset
//   complete_instr   : instruction memory returned valid IMem_dout this cycle
//   complete_data    : data memory access finished this cycle
//   IMem_dout[15:0]  : instruction currently being fetched
//   IR[15:0]         : instruction held in decode
//   IR_Exec[15:0]    : instruction held in execute
//   NZP[2:0]         : current condition codes
//   enable_updatePC  : PC register load enable
//   enable_fetch     : fetch stage enable
//   enable_decode    : decode stage enable (qualifies decode outputs)
//   enable_execute   : execute stage enable
//   enable_writeback : writeback enable
//   br_taken         : PC loads branch/jump target
//   mem_state[1:0]   : memory FSM state, 0 read, 1 indirect, 2 write, 3 idle
//   bypass_alu_1/2   : execute src1/src2 taken from the ALU result
//
// Handshake: the memory side has no ready/valid pair. complete_instr and
// complete_data are single-cycle "done" strobes sampled on the rising edge;
// a memory state is left on the edge that samples complete_data = 1, and
// enable_updatePC only loads on edges following a cycle with complete_instr.
// ---------------------------------------------------------------------------
module lc3_pipeline_ctrl #(
    parameter int FILL_DEPTH = 3,
    parameter int CTRL_STALL = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IMem_dout,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] MEM_RD   = 2'd0;
    localparam logic [1:0] MEM_IND  = 2'd1;
    localparam logic [1:0] MEM_WR   = 2'd2;
    localparam logic [1:0] MEM_IDLE = 2'd3;

    localparam int SW = (CTRL_STALL < 2) ? 1 : $clog2(CTRL_STALL + 1);
    localparam logic [SW-1:0] STALL_LOAD = SW'(CTRL_STALL);
    localparam logic [1:0]    FILL_WB    = 2'(FILL_DEPTH);
    localparam logic [1:0]    FILL_EX    = 2'(FILL_DEPTH - 1);
    localparam logic [1:0]    FILL_DE    = 2'(FILL_DEPTH - 2);

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
    endfunction

    logic [3:0] fetch_op, dec_op, exec_op;
    assign fetch_op = IMem_dout[15:12];
    assign dec_op   = IR[15:12];
    assign exec_op  = IR_Exec[15:12];

    // Registered state
    logic [1:0]    mem_next;
    logic          ind_store, ind_store_next;   // indirect access ends in a write (STI)
    logic          mem_retire;                  // memory FSM returned to idle last edge
    logic [1:0]    fill_cnt, fill_next;
    logic [SW-1:0] stall_cnt, stall_next;
    logic          upd_q;
    logic          upd_next, fetch_next, decode_next, execute_next, wb_next;
    logic          mem_stall_next, ctrl_detect;
    logic          byp1_next, byp2_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_state        <= MEM_IDLE;
            ind_store        <= 1'b0;
            mem_retire       <= 1'b0;
            fill_cnt         <= 2'd0;
            stall_cnt        <= '0;
            upd_q            <= 1'b0;
            enable_fetch     <= 1'b0;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
            bypass_alu_1     <= 1'b0;
            bypass_alu_2     <= 1'b0;
        end else begin
            mem_state        <= mem_next;
            ind_store        <= ind_store_next;
            mem_retire       <= (mem_state != MEM_IDLE) && (mem_next == MEM_IDLE);
            fill_cnt         <= fill_next;
            stall_cnt        <= stall_next;
            upd_q            <= upd_next;
            enable_fetch     <= fetch_next;
            enable_decode    <= decode_next;
            enable_execute   <= execute_next;
            enable_writeback <= wb_next;
            if (enable_decode) begin
                bypass_alu_1 <= byp1_next;
                bypass_alu_2 <= byp2_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        mem_next       = mem_state;
        ind_store_next = ind_store;
        case (mem_state)
            MEM_IDLE: begin
                // While stalled the execute stage holds IR_Exec, so the
                // instruction that just finished is still visible on the
                // cycle after retiring; mem_retire keeps it from re-entering.
                if (enable_execute && !mem_retire) begin
                    case (exec_op)
                        OP_LD, OP_LDR: mem_next = MEM_RD;
                        OP_ST, OP_STR: mem_next = MEM_WR;
                        OP_LDI: begin
                            mem_next       = MEM_IND;
                            ind_store_next = 1'b0;
                        end
                        OP_STI: begin
                            mem_next       = MEM_IND;
                            ind_store_next = 1'b1;
                        end
                        default: mem_next = MEM_IDLE;
                    endcase
                end
            end
            MEM_IND: begin
                if (complete_data) mem_next = ind_store ? MEM_WR : MEM_RD;
            end
            MEM_RD, MEM_WR: begin
                if (complete_data) mem_next = MEM_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: next values of the registered enables plus br_taken
    // ------------------------------------------------------------------
    always_comb begin
        mem_stall_next = (mem_next != MEM_IDLE);
        fill_next      = (fill_cnt >= FILL_WB) ? fill_cnt : fill_cnt + 2'd1;

        // A control fetch is ignored during a memory stall and loses to a
        // memory entry in the same cycle.
        ctrl_detect = enable_fetch && complete_instr &&
                      ((fetch_op == OP_BR) || (fetch_op == OP_JMP)) &&
                      (mem_state == MEM_IDLE) && !mem_stall_next;

        stall_next = stall_cnt;
        if (ctrl_detect)
            stall_next = STALL_LOAD;
        else if ((stall_cnt != '0) && (mem_state == MEM_IDLE))
            stall_next = stall_cnt - 1'b1;

        fetch_next   = !mem_stall_next && (stall_next == '0);
        // The very first PC load after reset does not wait for instruction memory.
        upd_next     = fetch_next && (complete_instr || (fill_cnt == 2'd0));
        decode_next  = !mem_stall_next && (fill_cnt >= FILL_DE);
        execute_next = !mem_stall_next && (fill_cnt >= FILL_EX);
        // Writeback follows a completed read; a completed store writes nothing back.
        wb_next      = !mem_stall_next && (fill_cnt >= FILL_WB) && (mem_state != MEM_WR);

        byp1_next = is_alu(exec_op) &&
                    ((dec_op == OP_ADD) || (dec_op == OP_AND) || (dec_op == OP_NOT) ||
                     (dec_op == OP_STR) || (dec_op == OP_LDR) || (dec_op == OP_JMP)) &&
                    (IR_Exec[11:9] == IR[8:6]);
        byp2_next = is_alu(exec_op) &&
                    ((dec_op == OP_ADD) || (dec_op == OP_AND)) && !IR[5] &&
                    (IR_Exec[11:9] == IR[2:0]);

        // enable_execute is only high while the memory FSM is idle, so a
        // memory stall always overrides the branch PC update.
        br_taken = enable_execute &&
                   ((exec_op == OP_JMP) ||
                    ((exec_op == OP_BR) && ((IR_Exec[11:9] & NZP) != 3'b000)));
        // The target load happens in the execute cycle itself, overriding
        // the control-stall hold on the PC.
        enable_updatePC = upd_q || br_taken;
    end

    logic unused_bits;
    assign unused_bits = ^{IMem_dout[11:0], IR[11:9], IR[4:3], IR_Exec[8:0]};

endmodule

// File: tb/tb_lc3_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lc3_pipeline_ctrl
//
// Directed testbench for lc3_pipeline_ctrl. Inputs are driven and outputs
// sampled 1 time unit after the rising edge; every expected value below is
// hand-derived from the sequencer behaviour.
// ---------------------------------------------------------------------------
module tb_lc3_pipeline_ctrl;

    localparam logic [15:0] NOP      = 16'h1020;  // ADD R0,R0,#0
    localparam logic [15:0] LDI_R1   = 16'hA200;
    localparam logic [15:0] ST_R0    = 16'h3000;
    localparam logic [15:0] BR_NZP   = 16'h0E05;
    localparam logic [15:0] BR_N     = 16'h0805;
    localparam logic [15:0] JMP_R7   = 16'hC1C0;
    localparam logic [15:0] ADD_R3   = 16'h1642;  // ADD R3,R1,R2
    localparam logic [15:0] ADD_R4R  = 16'h18C3;  // ADD R4,R3,R3
    localparam logic [15:0] ADD_R4I  = 16'h18E3;  // ADD R4,R3,#3

    // Clock / reset
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        complete_instr, complete_data;
    logic [15:0] IMem_dout, IR, IR_Exec;
    logic [2:0]  NZP;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute;
    logic        enable_writeback, br_taken, bypass_alu_1, bypass_alu_2;
    logic [1:0]  mem_state;

    lc3_pipeline_ctrl dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IMem_dout        (IMem_dout),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .NZP              (NZP),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .mem_state        (mem_state),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected {updatePC, fetch, decode, execute, writeback}
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_defaults();
        complete_instr = 1'b1;
        complete_data  = 1'b0;
        IMem_dout      = NOP;
        IR             = NOP;
        IR_Exec        = NOP;
        NZP            = 3'b010;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, {11'd0, enable_updatePC, enable_fetch, enable_decode,
                             enable_execute, enable_writeback}, 16'h0000);
        check({tag, "_br"}, {15'd0, br_taken}, 16'h0000);
        check({tag, "_byp"}, {14'd0, bypass_alu_1, bypass_alu_2}, 16'h0000);
        check({tag, "_mem"}, {14'd0, mem_state}, 16'h0003);
    endtask

    task automatic check_fill(input string tag);
        logic [4:0] exp_en;
        exp_q.push_back(5'b11000);
        exp_q.push_back(5'b11100);
        exp_q.push_back(5'b11110);
        exp_q.push_back(5'b11111);
        while (exp_q.size() > 0) begin
            tick(1);
            exp_en = exp_q.pop_front();
            check(tag, {11'd0, enable_updatePC, enable_fetch, enable_decode,
                        enable_execute, enable_writeback}, {11'd0, exp_en});
            check({tag, "_mem"}, {14'd0, mem_state}, 16'h0003);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        drive_defaults();

        // Reset values
        tick(2);
        check_reset_outputs("reset");

        // Pipeline fill with NOPs
        reset_n = 1'b1;
        check_fill("fill");

        // Bypass selection
        IR_Exec = ADD_R3;
        IR      = ADD_R4R;
        tick(1);
        check("byp1_reg", {15'd0, bypass_alu_1}, 16'h0001);
        check("byp2_reg", {15'd0, bypass_alu_2}, 16'h0001);
        IR = ADD_R4I;
        tick(1);
        check("byp1_imm", {15'd0, bypass_alu_1}, 16'h0001);
        check("byp2_imm", {15'd0, bypass_alu_2}, 16'h0000);
        IR_Exec = NOP;
        IR      = ADD_R4R;
        tick(1);
        check("byp1_nodep", {15'd0, bypass_alu_1}, 16'h0000);
        check("byp2_nodep", {15'd0, bypass_alu_2}, 16'h0000);
        IR = NOP;

        // LDI: idle -> 1 -> 0 -> idle, two cycles in each state
        IR_Exec = LDI_R1;
        tick(1);
        IR_Exec = NOP;
        check("ldi_enter", {14'd0, mem_state}, 16'h0001);
        check("ldi_stall_en", {12'd0, enable_fetch, enable_decode, enable_execute,
                               enable_writeback}, 16'h0000);
        tick(1);
        check("ldi_hold1", {14'd0, mem_state}, 16'h0001);
        complete_data = 1'b1;
        tick(1);
        complete_data = 1'b0;
        check("ldi_rd", {14'd0, mem_state}, 16'h0000);
        check("ldi_rd_en", {11'd0, enable_updatePC, enable_fetch, enable_decode,
                            enable_execute, enable_writeback}, 16'h0000);
        tick(1);
        check("ldi_hold0", {14'd0, mem_state}, 16'h0000);
        complete_data = 1'b1;
        tick(1);
        complete_data = 1'b0;
        check("ldi_done", {14'd0, mem_state}, 16'h0003);
        check("ldi_wb", {15'd0, enable_writeback}, 16'h0001);
        check("ldi_resume", {13'd0, enable_fetch, enable_decode, enable_execute}, 16'h0007);
        tick(1);
        check("ldi_no_reentry", {14'd0, mem_state}, 16'h0003);

        // Taken branch: fetch held for three cycles, PC update in execute cycle
        IMem_dout = BR_NZP;
        tick(1);
        IMem_dout = NOP;
        check("brt_fetch0", {14'd0, enable_fetch, enable_updatePC}, 16'h0000);
        tick(2);
        check("brt_fetch2", {14'd0, enable_fetch, enable_updatePC}, 16'h0000);
        check("brt_pre", {15'd0, br_taken}, 16'h0000);
        IR_Exec = BR_NZP;
        NZP     = 3'b010;
        #1;
        check("brt_taken", {15'd0, br_taken}, 16'h0001);
        check("brt_updpc", {15'd0, enable_updatePC}, 16'h0001);
        IR_Exec = NOP;
        #1;
        check("brt_after", {14'd0, br_taken, enable_updatePC}, 16'h0000);
        tick(1);
        check("brt_resume", {14'd0, enable_fetch, enable_updatePC}, 16'h0003);

        // Not-taken branch
        IMem_dout = BR_N;
        tick(1);
        IMem_dout = NOP;
        check("brn_fetch0", {15'd0, enable_fetch}, 16'h0000);
        IR_Exec = BR_N;
        NZP     = 3'b000;
        #1;
        check("brn_nzp000", {14'd0, br_taken, enable_updatePC}, 16'h0000);
        NZP = 3'b010;
        #1;
        check("brn_nzp010", {15'd0, br_taken}, 16'h0000);
        IR_Exec = JMP_R7;
        #1;
        check("jmp_taken", {14'd0, br_taken, enable_updatePC}, 16'h0003);
        IR_Exec = NOP;
        tick(2);
        check("brn_fetch2", {15'd0, enable_fetch}, 16'h0000);
        tick(1);
        check("brn_resume", {15'd0, enable_fetch}, 16'h0001);

        // Instruction memory wait for four cycles
        complete_instr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("imem_wait", {15'd0, enable_updatePC}, 16'h0000);
        end
        complete_instr = 1'b1;
        tick(1);
        check("imem_resume", {14'd0, enable_updatePC, enable_fetch}, 16'h0003);

        // Store, then reset mid-access
        IR_Exec = ST_R0;
        tick(1);
        check("st_enter", {14'd0, mem_state}, 16'h0002);
        IR_Exec = NOP;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick(2);
        reset_n = 1'b1;
        check_fill("refill");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
